tdma_dispatcher: RTL and testbench

- Sits directly downstream of the TDMA slot generator, between the per-core request ports and the memory-side request channel.
- Buffers requests from QUEUE_NUMBER sources in per-queue FIFOs.
- Forwards requests to a single output channel, drawing only from the queue that the TDMA `selection` currently grants.
- Enforces valid/ready handshake stability across slot changes.

---
 rtl/tdma_dispatcher.sv | 80 ++++++++
 tb/tb_tdma_dispatcher.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdma_dispatcher.sv
// tdma_dispatcher: per-queue request FIFOs forwarded to one output register, loading only from the TDMA-granted queue
module tdma_dispatcher #(
  parameter int QUEUE_NUMBER = 4,
  parameter int WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int SW = QUEUE_NUMBER > 1 ? $clog2(QUEUE_NUMBER) : 1,
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic [SW-1:0] selection,
  input  logic [QUEUE_NUMBER-1:0] in_valid,
  output logic [QUEUE_NUMBER-1:0] in_ready,
  input  logic [QUEUE_NUMBER-1:0][WIDTH-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0] out_source,
  output logic [QUEUE_NUMBER-1:0][CW-1:0] fifo_count
);
  typedef enum logic {EMPTY, LOADED} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [QUEUE_NUMBER][FIFO_DEPTH];
  logic [PW-1:0] wptr [QUEUE_NUMBER];
  logic [PW-1:0] rptr [QUEUE_NUMBER];
  logic [QUEUE_NUMBER-1:0] push, pop;
  logic [WIDTH-1:0] rd;
  logic free, load;
  assign free = state == EMPTY || out_ready;
  assign load = |pop;
  assign out_valid = state == LOADED;
  always_comb begin
    in_ready = '0;
    push = '0;
    for (int q = 0; q < QUEUE_NUMBER; q++) begin
      in_ready[q] = fifo_count[q] != CW'(FIFO_DEPTH);
      push[q] = in_valid[q] && in_ready[q];
    end
  end
  // an out-of-range selection matches no queue, so nothing is popped
  always_comb begin
    pop = '0;
    rd = '0;
    for (int q = 0; q < QUEUE_NUMBER; q++) begin
      pop[q] = free && selection == SW'(q) && fifo_count[q] != '0;
      if (pop[q]) rd = mem[q][rptr[q]];
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int q = 0; q < QUEUE_NUMBER; q++) begin
        wptr[q] <= '0;
        rptr[q] <= '0;
        fifo_count[q] <= '0;
      end
    end else begin
      for (int q = 0; q < QUEUE_NUMBER; q++) begin
        if (push[q]) wptr[q] <= wptr[q] + 1'b1;
        if (pop[q]) rptr[q] <= rptr[q] + 1'b1;
        fifo_count[q] <= fifo_count[q] + CW'(push[q]) - CW'(pop[q]);
      end
    end
  always_ff @(posedge clock)
    for (int q = 0; q < QUEUE_NUMBER; q++)
      if (push[q]) mem[q][wptr[q]] <= in_data[q];
  always_comb state_nx = load ? LOADED : out_ready ? EMPTY : state;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= EMPTY;
      out_data <= '0;
      out_source <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_data <= rd;
        out_source <= selection;
      end
    end
endmodule

// File: tb/tb_tdma_dispatcher.sv
// tb_tdma_dispatcher: directed stimulus checked against a queue-based model every cycle plus literal sequence checks
module tb_tdma_dispatcher;
  logic clock = 0, reset = 1;
  logic [1:0] selection = '0;
  logic [3:0] in_valid = '0, in_ready;
  logic [3:0][31:0] in_data = '0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_data;
  logic [1:0] out_source;
  logic [3:0][2:0] fifo_count;
  int n_cmp = 0, n_fail = 0, cyc = 0, acc = 0;
  typedef struct {int src; int d; int cyc;} ent_t;
  ent_t log_q[$];
  logic [31:0] mq[4][$];
  logic m_valid = 0;
  logic [31:0] m_data = 0;
  int m_src = 0;
  logic [3:0] m_acc;

  tdma_dispatcher #(.QUEUE_NUMBER(4), .WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .selection(selection),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_source(out_source), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_seq(string name, int s[8], int d[8], int n);
    chk({name, "_len"}, 64'(log_q.size()), 64'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk({name, "_src"}, 64'(log_q[i].src), 64'(s[i]));
      chk({name, "_data"}, 64'(log_q[i].d), 64'(d[i]));
    end
  endtask

  // model: FIFOs as queues; pop decision uses pre-edge occupancy, so pushes are never visible the same edge
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < 4; q++) mq[q].delete();
      m_valid = 0;
      m_data = 0;
      m_src = 0;
    end else begin
      for (int q = 0; q < 4; q++) m_acc[q] = in_valid[q] && mq[q].size() < 4;
      if (!m_valid || out_ready) begin
        if (mq[selection].size() != 0) begin
          m_data = mq[selection].pop_front();
          m_src = int'(selection);
          m_valid = 1;
        end else m_valid = 0;
      end
      for (int q = 0; q < 4; q++) if (m_acc[q]) mq[q].push_back(in_data[q]);
    end
  end

  always @(posedge clock) begin
    cyc++;
    if (reset && out_valid && out_ready) log_q.push_back('{int'(out_source), int'(out_data), cyc});
  end

  always @(negedge clock) begin
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_source", 64'(out_source), 64'(m_src));
    end
    if (!reset) chk("reset_out_data", 64'(out_data), 64'(0));
    for (int q = 0; q < 4; q++) begin
      chk("fifo_count", 64'(fifo_count[q]), 64'(mq[q].size()));
      chk("in_ready", 64'(in_ready[q]), 64'(mq[q].size() < 4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 0;
    in_valid = '1;
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'hF);
    in_valid = '0;
    reset = 1;
    step();

    selection = 0;
    out_ready = 1;
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0001;
      in_data[0] = 32'hA0 + 32'(i);
      step();
      if (i == 1) chk("burst_latency", {31'(0), out_valid, out_data}, {31'(0), 1'b1, 32'hA0});
    end
    in_valid = '0;
    repeat (6) step();
    chk_seq("burst", '{0, 0, 0, 0, 0, 0, 0, 0}, '{'hA0, 'hA1, 'hA2, 'hA3, 0, 0, 0, 0}, 4);
    for (int i = 1; i < 4 && i < log_q.size(); i++)
      chk("burst_b2b", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'(1));

    selection = 1;
    out_ready = 0;
    log_q.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 4'b0010;
      in_data[1] = 32'hC0 + 32'(i);
      if (i == 4) chk("bp_ready_before_5th", 64'(in_ready[1]), 64'(1));
      if (in_ready[1]) acc++;
      step();
    end
    in_valid = '0;
    chk("bp_accepts", 64'(acc), 64'(5));
    chk("bp_count", 64'(fifo_count[1]), 64'(4));
    chk("bp_ready", 64'(in_ready[1]), 64'(0));
    chk("bp_held", 64'(out_data), 64'hC0);
    out_ready = 1;
    repeat (7) step();
    chk_seq("bp", '{1, 1, 1, 1, 1, 0, 0, 0}, '{'hC0, 'hC1, 'hC2, 'hC3, 'hC4, 0, 0, 0}, 5);

    selection = 2;
    out_ready = 0;
    log_q.delete();
    in_valid = 4'b1100;
    in_data[2] = 32'hB0;
    in_data[3] = 32'hD0;
    step();
    in_valid = '0;
    step();
    selection = 3;
    repeat (3) step();
    chk("slot_hold_data", 64'(out_data), 64'hB0);
    chk("slot_hold_src", 64'(out_source), 64'(2));
    chk("slot_q3_count", 64'(fifo_count[3]), 64'(1));
    out_ready = 1;
    step();
    chk("slot_next_data", 64'(out_data), 64'hD0);
    chk("slot_next_src", 64'(out_source), 64'(3));
    step();
    chk_seq("slot", '{2, 3, 0, 0, 0, 0, 0, 0}, '{'hB0, 'hD0, 0, 0, 0, 0, 0, 0}, 2);

    selection = 0;
    out_ready = 0;
    log_q.delete();
    in_valid = '1;
    for (int q = 0; q < 4; q++) in_data[q] = 32'(q << 4);
    step();
    for (int q = 0; q < 4; q++) in_data[q] = 32'((q << 4) | 1);
    step();
    in_valid = '0;
    out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      selection = 2'(s);
      repeat (2) step();
    end
    selection = 0;
    step();
    chk_seq("rotate", '{0, 0, 1, 1, 2, 2, 3, 3}, '{'h00, 'h01, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31}, 8);

    out_ready = 0;
    in_valid = '1;
    for (int q = 0; q < 4; q++) in_data[q] = 32'hE0 + 32'(q);
    repeat (2) step();
    in_valid = '0;
    chk("mid_pre_valid", 64'(out_valid), 64'(1));
    chk("mid_pre_count", 64'(fifo_count[1]), 64'(2));
    #2 reset = 0;
    #1;
    chk("mid_valid", 64'(out_valid), 64'(0));
    chk("mid_count", 64'(fifo_count), 64'(0));
    chk("mid_ready", 64'(in_ready), 64'hF);
    step();
    reset = 1;
    repeat (2) step();
    chk("post_valid", 64'(out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
